// File: rtl/seq_multiplier.sv
// -----------------------------------------------------------------------------
// seq_multiplier
//   Iterative shift-add multiplier. It accumulates one partial product per
//   clock through a single WIDTH+1-bit adder. Signed operands are converted to
//   magnitudes when they are latched, and the sign is put back on the final
//   product.
//
// Ports
//   clk          rising-edge clock
//   reset        synchronous, active-high; discards any operation in flight
//   start        operation request, accepted only while not busy
//   signed_mode  1 = two's-complement operands and product, 0 = unsigned
//   a, b         multiplicand / multiplier (WIDTH bits), latched with start
//   busy         high during the WIDTH accumulate cycles
//   done         one-cycle pulse when p carries a new result
//   p            2*WIDTH-bit product, held until the next result
// -----------------------------------------------------------------------------
module seq_multiplier #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               signed_mode,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] p
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FINISH
    } state_t;

    state_t               state_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [WIDTH-1:0]     mcand_q;   // multiplicand magnitude
    logic [WIDTH-1:0]     acc_q;     // upper half of the running product
    logic [WIDTH-1:0]     mplier_q;  // multiplier bits, refilled with product low bits
    logic                 neg_q;
    logic                 busy_q;
    logic                 done_q;
    logic [2*WIDTH-1:0]   p_q;

    logic [WIDTH:0]       sum_d;
    logic [2*WIDTH-1:0]   prod_d;
    logic [2*WIDTH-1:0]   p_d;

    // The magnitude of the most negative value is 2^(WIDTH-1). That still fits
    // in WIDTH unsigned bits, so plain negation is exact here.
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v,
                                                   input logic             is_signed);
        return (is_signed && v[WIDTH-1]) ? (~v + 1'b1) : v;
    endfunction

    // One accumulate step. prod_d is {carry, acc, multiplier} after the shift,
    // so on the last step it is already the full unsigned product.
    always_comb begin
        sum_d  = {1'b0, acc_q} + (mplier_q[0] ? {1'b0, mcand_q} : {(WIDTH+1){1'b0}});
        prod_d = {sum_d, mplier_q[WIDTH-1:1]};
        p_d    = neg_q ? (~prod_d + 1'b1) : prod_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            mcand_q  <= '0;
            acc_q    <= '0;
            mplier_q <= '0;
            neg_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            p_q      <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE, FINISH: begin
                    if (start) begin
                        mcand_q  <= magnitude(a, signed_mode);
                        mplier_q <= magnitude(b, signed_mode);
                        acc_q    <= '0;
                        neg_q    <= signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
                        cnt_q    <= CNT_W'(WIDTH);
                        busy_q   <= 1'b1;
                        state_q  <= RUN;
                    end else begin
                        state_q  <= IDLE;
                    end
                end
                RUN: begin
                    acc_q    <= sum_d[WIDTH:1];
                    mplier_q <= {sum_d[0], mplier_q[WIDTH-1:1]};
                    cnt_q    <= cnt_q - 1'b1;
                    if (cnt_q == CNT_W'(1)) begin
                        p_q     <= p_d;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= FINISH;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign p    = p_q;

endmodule
